// File: rtl/if_pkg.sv
// Shared types and constants for the IF-stage fetch unit (if_fetch_unit, if_id_buffer).
package if_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

    localparam int unsigned INSTR_BYTES  = 2;
    localparam logic [15:0] RESET_VECTOR = 16'h0000;
    localparam logic [15:0] INSTR_NOP    = 16'h0000;

endpackage

// File: rtl/if_id_buffer.sv
// One-entry valid/ready holding register between the fetch unit and the ID stage.
module if_id_buffer #(
    parameter int unsigned AddrWidth  = 16,
    parameter int unsigned InstrWidth = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  capture,
    input  logic                  consume,
    input  logic                  flush,
    input  logic [InstrWidth-1:0] instr_in,
    input  logic [AddrWidth-1:0]  pc_in,
    output logic                  valid,
    output logic [InstrWidth-1:0] instr,
    output logic [AddrWidth-1:0]  pc
);

    // Flush beats capture beats consume; a capture and a consume at the same
    // edge leave the entry occupied by the new instruction.
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (capture) begin
            valid <= 1'b1;
        end else if (consume) begin
            valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr <= '0;
            pc    <= '0;
        end else if (capture && !flush) begin
            instr <= instr_in;
            pc    <= pc_in;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// IF-stage fetch sequencer: PC_Next mux, single-outstanding IMem request FSM, ID handoff.
// Optional build macro IF_STALL_COUNT_EN adds the Stall_Count output.
module if_fetch_unit
    import if_pkg::*;
#(
    parameter int unsigned          AddrWidth   = 16,
    parameter int unsigned          InstrWidth  = 16,
    parameter int unsigned          InstrBytes  = INSTR_BYTES,
    parameter logic [AddrWidth-1:0] ResetVector = AddrWidth'(RESET_VECTOR)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [AddrWidth-1:0]  PC,
    output logic [AddrWidth-1:0]  PC_Next,
    output logic                  IMem_Req,
    output logic [AddrWidth-1:0]  IMem_Addr,
    input  logic                  IMem_Ack,
    input  logic [InstrWidth-1:0] IMem_Data,
    input  logic                  Branch_Taken,
    input  logic [AddrWidth-1:0]  Branch_Target,
    output logic                  ID_Valid,
    input  logic                  ID_Ready,
    output logic [InstrWidth-1:0] ID_Instr,
    output logic [AddrWidth-1:0]  ID_PC
`ifdef IF_STALL_COUNT_EN
    ,
    output logic [15:0]           Stall_Count
`endif
);

    fetch_state_e state_q;
    fetch_state_e state_d;
    logic         issue;
    logic         capture;
    logic         buf_free;
    logic         consume;

    assign consume  = ID_Valid && ID_Ready;
    assign buf_free = !ID_Valid || ID_Ready;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: defaults first so no path leaves a signal unassigned (no latch).
    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (!Branch_Taken && buf_free) begin
                    issue   = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (IMem_Ack) begin
                    capture = !Branch_Taken;
                    state_d = IDLE;
                end else if (Branch_Taken) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                if (IMem_Ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The request is outstanding exactly while the FSM is out of IDLE, so reset
    // withdraws it immediately.
    assign IMem_Req = (state_q != IDLE);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            IMem_Addr <= '0;
        end else if (issue) begin
            IMem_Addr <= PC;
        end
    end

    always_comb begin
        PC_Next = PC;
        if (!RST) begin
            PC_Next = ResetVector;
        end else if (Branch_Taken) begin
            PC_Next = Branch_Target;
        end else if (capture) begin
            PC_Next = PC + AddrWidth'(InstrBytes);
        end
    end

    if_id_buffer #(
        .AddrWidth (AddrWidth),
        .InstrWidth(InstrWidth)
    ) u_id_buffer (
        .clk     (CLK),
        .rst_n   (RST),
        .capture (capture),
        .consume (consume),
        .flush   (Branch_Taken),
        .instr_in(IMem_Data),
        .pc_in   (IMem_Addr),
        .valid   (ID_Valid),
        .instr   (ID_Instr),
        .pc      (ID_PC)
    );

`ifdef IF_STALL_COUNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            stall_q <= '0;
        end else if (Branch_Taken) begin
            stall_q <= '0;
        end else if (ID_Valid && !ID_Ready && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign Stall_Count = stall_q;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: vector table, directed corner cases, randomized run vs model.
module tb_if_fetch_unit;
    import if_pkg::*;

    localparam logic [15:0] RV = RESET_VECTOR;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [15:0] PC = RV;
    logic [15:0] PC_Next;
    logic        IMem_Req;
    logic [15:0] IMem_Addr;
    logic        IMem_Ack = 1'b0;
    logic [15:0] IMem_Data = INSTR_NOP;
    logic        Branch_Taken = 1'b0;
    logic [15:0] Branch_Target = '0;
    logic        ID_Valid;
    logic        ID_Ready = 1'b0;
    logic [15:0] ID_Instr;
    logic [15:0] ID_PC;
`ifdef IF_STALL_COUNT_EN
    logic [15:0] Stall_Count;
`endif

    if_fetch_unit dut (
        .CLK          (CLK),
        .RST          (RST),
        .PC           (PC),
        .PC_Next      (PC_Next),
        .IMem_Req     (IMem_Req),
        .IMem_Addr    (IMem_Addr),
        .IMem_Ack     (IMem_Ack),
        .IMem_Data    (IMem_Data),
        .Branch_Taken (Branch_Taken),
        .Branch_Target(Branch_Target),
        .ID_Valid     (ID_Valid),
        .ID_Ready     (ID_Ready),
        .ID_Instr     (ID_Instr),
        .ID_PC        (ID_PC)
`ifdef IF_STALL_COUNT_EN
        ,
        .Stall_Count  (Stall_Count)
`endif
    );

    always #5 CLK = ~CLK;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] s_pc_next;

    typedef struct {
        logic        rdy;
        logic        br;
        logic [15:0] tgt;
        logic        ack;
        logic [15:0] data;
        logic [15:0] exp_pc_next;
        logic        exp_req;
        logic [15:0] exp_addr;
        logic        exp_valid;
        logic [15:0] exp_instr;
        logic [15:0] exp_pc;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rdy, input logic br, input logic [15:0] tgt,
                         input logic ack, input logic [15:0] data);
        ID_Ready      = rdy;
        Branch_Taken  = br;
        Branch_Target = tgt;
        IMem_Ack      = ack;
        IMem_Data     = data;
    endtask

    // One clock: drive at negedge, sample PC_Next just before the edge, then the
    // environment's PC register loads it just after the edge.
    task automatic cyc(input logic rdy, input logic br, input logic [15:0] tgt,
                       input logic ack, input logic [15:0] data);
        @(negedge CLK);
        drive(rdy, br, tgt, ack, data);
        #4;
        s_pc_next = PC_Next;
        @(posedge CLK);
        #1;
        PC = s_pc_next;
    endtask

    task automatic expect_out(input string tag, input logic [15:0] pcn, input logic req,
                              input logic [15:0] addr, input logic valid,
                              input logic [15:0] instr, input logic [15:0] ipc);
        check({tag, "_pc_next"}, 32'(s_pc_next), 32'(pcn));
        check({tag, "_req"}, 32'(IMem_Req), 32'(req));
        if (req) check({tag, "_addr"}, 32'(IMem_Addr), 32'(addr));
        check({tag, "_valid"}, 32'(ID_Valid), 32'(valid));
        if (valid) begin
            check({tag, "_instr"}, 32'(ID_Instr), 32'(instr));
            check({tag, "_idpc"}, 32'(ID_PC), 32'(ipc));
        end
    endtask

    // Holds reset across two edges with hostile inputs, checks the reset state,
    // and releases just after an edge so the next cyc() edge is the first live one.
    task automatic reset_dut();
        RST = 1'b0;
        PC  = 16'h1234;
        drive(1'b1, 1'b1, 16'h5678, 1'b1, 16'hBEEF);
        repeat (2) @(posedge CLK);
        #1;
        check("rst_pc_next", 32'(PC_Next), 32'(RV));
        check("rst_req", 32'(IMem_Req), 32'd0);
        check("rst_addr", 32'(IMem_Addr), 32'd0);
        check("rst_valid", 32'(ID_Valid), 32'd0);
        check("rst_instr", 32'(ID_Instr), 32'd0);
        check("rst_idpc", 32'(ID_PC), 32'd0);
`ifdef IF_STALL_COUNT_EN
        check("rst_stall", 32'(Stall_Count), 32'd0);
`endif
        PC = RV;
        drive(1'b0, 1'b0, 16'h0000, 1'b0, INSTR_NOP);
        #1;
        RST = 1'b1;
    endtask

    function automatic vec_t v(input logic rdy, input logic br, input logic [15:0] tgt,
                               input logic ack, input logic [15:0] data,
                               input logic [15:0] pcn, input logic req, input logic [15:0] addr,
                               input logic valid, input logic [15:0] instr, input logic [15:0] ipc);
        vec_t r;
        r.rdy = rdy; r.br = br; r.tgt = tgt; r.ack = ack; r.data = data;
        r.exp_pc_next = pcn; r.exp_req = req; r.exp_addr = addr;
        r.exp_valid = valid; r.exp_instr = instr; r.exp_pc = ipc;
        return r;
    endfunction

    // Reference model state: one in-flight fetch (possibly doomed) and one held entry.
    bit          m_busy;
    bit          m_doomed;
    bit          m_valid;
    logic [15:0] m_addr;
    logic [15:0] m_instr;
    logic [15:0] m_ipc;
    int          m_stall;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Sequential fetch, backpressure, idle/coincident redirects, idle ack.
        vecs.push_back(v(1, 0, 16'h0000, 0, INSTR_NOP, 16'h0000, 1, 16'h0000, 0, 16'h0000, 16'h0000));
        vecs.push_back(v(1, 0, 16'h0000, 1, 16'h1234, 16'h0002, 0, 16'h0000, 1, 16'h1234, 16'h0000));
        for (int i = 0; i < 5; i++)
            vecs.push_back(v(0, 0, 16'h0000, 0, INSTR_NOP, 16'h0002, 0, 16'h0000, 1, 16'h1234, 16'h0000));
        vecs.push_back(v(1, 0, 16'h0000, 0, INSTR_NOP, 16'h0002, 1, 16'h0002, 0, 16'h0000, 16'h0000));
        vecs.push_back(v(1, 0, 16'h0000, 1, 16'hABCD, 16'h0004, 0, 16'h0000, 1, 16'hABCD, 16'h0002));
        vecs.push_back(v(1, 1, 16'h0040, 0, INSTR_NOP, 16'h0040, 0, 16'h0000, 0, 16'h0000, 16'h0000));
        vecs.push_back(v(1, 0, 16'h0000, 0, INSTR_NOP, 16'h0040, 1, 16'h0040, 0, 16'h0000, 16'h0000));
        vecs.push_back(v(1, 1, 16'h0080, 1, 16'h1111, 16'h0080, 0, 16'h0000, 0, 16'h0000, 16'h0000));
        vecs.push_back(v(1, 0, 16'h0000, 0, INSTR_NOP, 16'h0080, 1, 16'h0080, 0, 16'h0000, 16'h0000));
        vecs.push_back(v(0, 0, 16'h0000, 1, 16'h2222, 16'h0082, 0, 16'h0000, 1, 16'h2222, 16'h0080));
        vecs.push_back(v(0, 0, 16'h0000, 1, 16'h3333, 16'h0082, 0, 16'h0000, 1, 16'h2222, 16'h0080));
        vecs.push_back(v(1, 1, 16'h0100, 0, INSTR_NOP, 16'h0100, 0, 16'h0000, 0, 16'h0000, 16'h0000));

        reset_dut();
        foreach (vecs[i]) begin
            cyc(vecs[i].rdy, vecs[i].br, vecs[i].tgt, vecs[i].ack, vecs[i].data);
            expect_out($sformatf("vec%0d", i), vecs[i].exp_pc_next, vecs[i].exp_req,
                       vecs[i].exp_addr, vecs[i].exp_valid, vecs[i].exp_instr, vecs[i].exp_pc);
        end

        // Redirect while waiting on a 3-cycle memory, then a second redirect in DROP.
        cyc(1, 0, 16'h0000, 0, INSTR_NOP);
        expect_out("drop_issue", 16'h0100, 1, 16'h0100, 0, 16'h0000, 16'h0000);
        cyc(1, 1, 16'h0040, 0, INSTR_NOP);
        expect_out("drop_br1", 16'h0040, 1, 16'h0100, 0, 16'h0000, 16'h0000);
        check("drop_state", 32'(dut.state_q), 32'(DROP));
        cyc(1, 1, 16'h0060, 0, INSTR_NOP);
        expect_out("drop_br2", 16'h0060, 1, 16'h0100, 0, 16'h0000, 16'h0000);
        cyc(1, 0, 16'h0000, 1, 16'hDEAD);
        expect_out("drop_ack", 16'h0060, 0, 16'h0000, 0, 16'h0000, 16'h0000);
        cyc(1, 0, 16'h0000, 0, INSTR_NOP);
        expect_out("drop_reissue", 16'h0060, 1, 16'h0060, 0, 16'h0000, 16'h0000);
        cyc(1, 0, 16'h0000, 1, 16'h4444);
        expect_out("drop_fetch", 16'h0062, 0, 16'h0000, 1, 16'h4444, 16'h0060);

        // PC wrap at the top of the address space.
        cyc(1, 1, 16'hFFFE, 0, INSTR_NOP);
        expect_out("wrap_br", 16'hFFFE, 0, 16'h0000, 0, 16'h0000, 16'h0000);
        cyc(1, 0, 16'h0000, 0, INSTR_NOP);
        expect_out("wrap_issue", 16'hFFFE, 1, 16'hFFFE, 0, 16'h0000, 16'h0000);
        cyc(1, 0, 16'h0000, 1, 16'h7777);
        expect_out("wrap_ack", 16'h0000, 0, 16'h0000, 1, 16'h7777, 16'hFFFE);

        // Asynchronous reset in the middle of an outstanding request.
        cyc(1, 1, 16'h0200, 0, INSTR_NOP);
        expect_out("arst_br", 16'h0200, 0, 16'h0000, 0, 16'h0000, 16'h0000);
        cyc(1, 0, 16'h0000, 0, INSTR_NOP);
        expect_out("arst_issue", 16'h0200, 1, 16'h0200, 0, 16'h0000, 16'h0000);
        @(negedge CLK);
        drive(1, 0, 16'h0000, 0, INSTR_NOP);
        #2;
        RST = 1'b0;
        #1;
        check("arst_req", 32'(IMem_Req), 32'd0);
        check("arst_valid", 32'(ID_Valid), 32'd0);
        check("arst_pc_next", 32'(PC_Next), 32'(RV));
        check("arst_addr", 32'(IMem_Addr), 32'd0);
        PC = RV;
        cyc(1, 0, 16'h0000, 1, 16'h9999);
        check("arst_hold_req", 32'(IMem_Req), 32'd0);
        check("arst_hold_valid", 32'(ID_Valid), 32'd0);
        RST = 1'b1;
        cyc(1, 0, 16'h0000, 1, 16'h9999);
        expect_out("arst_late_ack", RV, 1, RV, 0, 16'h0000, 16'h0000);
        cyc(0, 0, 16'h0000, 1, 16'h5555);
        expect_out("arst_fetch", RV + 16'd2, 0, 16'h0000, 1, 16'h5555, RV);

        // Seven stalled cycles with the entry held, then a redirect.
        for (int i = 0; i < 7; i++) begin
            cyc(0, 0, 16'h0000, 0, INSTR_NOP);
            expect_out($sformatf("stall%0d", i), RV + 16'd2, 0, 16'h0000, 1, 16'h5555, RV);
        end
`ifdef IF_STALL_COUNT_EN
        check("stall_count7", 32'(Stall_Count), 32'd7);
`endif
        cyc(0, 1, 16'h0010, 0, INSTR_NOP);
        expect_out("stall_br", 16'h0010, 0, 16'h0000, 0, 16'h0000, 16'h0000);
`ifdef IF_STALL_COUNT_EN
        check("stall_clear", 32'(Stall_Count), 32'd0);
`endif

        // Randomized run against the behavioural model.
        reset_dut();
        m_busy = 0; m_doomed = 0; m_valid = 0; m_stall = 0;
        m_addr = '0; m_instr = '0; m_ipc = '0;
        begin
            bit          mem_pending;
            int          mem_cnt;
            logic        rdy, br, ack, deliver, launch;
            logic [15:0] tgt, data, old_pc, exp_pcn;
            mem_pending = 0;
            mem_cnt     = 0;
            for (int n = 0; n < 3000; n++) begin
                @(negedge CLK);
                if (!IMem_Req) begin
                    mem_pending = 0;
                    ack = ($urandom_range(0, 7) == 0);
                end else begin
                    if (!mem_pending) begin
                        mem_pending = 1;
                        mem_cnt     = $urandom_range(0, 2);
                    end
                    ack = (mem_cnt == 0);
                    if (mem_cnt != 0) mem_cnt--;
                end
                rdy  = ($urandom_range(0, 3) != 0);
                br   = ($urandom_range(0, 11) == 0);
                tgt  = ($urandom_range(0, 3) == 0) ? 16'hFFFC : (16'($urandom) & 16'hFFFE);
                data = 16'($urandom);
                drive(rdy, br, tgt, ack, data);
                old_pc  = PC;
                deliver = m_busy && ack && !m_doomed && !br;
                exp_pcn = br ? tgt : (deliver ? old_pc + 16'd2 : old_pc);
                #4;
                check($sformatf("rnd%0d_pc_next", n), 32'(PC_Next), 32'(exp_pcn));
                s_pc_next = PC_Next;
                @(posedge CLK);
                #1;
                PC = s_pc_next;

                launch = !m_busy && !br && (!m_valid || rdy);
                if (br) m_stall = 0;
                else if (m_valid && !rdy && m_stall < 65535) m_stall++;
                if (br) m_valid = 0;
                else if (deliver) begin
                    m_valid = 1;
                    m_instr = data;
                    m_ipc   = m_addr;
                end else if (m_valid && rdy) m_valid = 0;
                if (m_busy) begin
                    if (ack) m_busy = 0;
                    else if (br) m_doomed = 1;
                end else if (launch) begin
                    m_busy   = 1;
                    m_doomed = 0;
                    m_addr   = old_pc;
                end

                check($sformatf("rnd%0d_req", n), 32'(IMem_Req), 32'(m_busy));
                if (m_busy) check($sformatf("rnd%0d_addr", n), 32'(IMem_Addr), 32'(m_addr));
                check($sformatf("rnd%0d_valid", n), 32'(ID_Valid), 32'(m_valid));
                if (m_valid) begin
                    check($sformatf("rnd%0d_instr", n), 32'(ID_Instr), 32'(m_instr));
                    check($sformatf("rnd%0d_idpc", n), 32'(ID_PC), 32'(m_ipc));
                end
`ifdef IF_STALL_COUNT_EN
                check($sformatf("rnd%0d_stall", n), 32'(Stall_Count), 32'(m_stall));
`endif
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch sequencer for the IF stage of the 16-bit pipelined processor.
- Reads the current PC from the PC register and drives that register's next value every cycle.
- Fetches one instruction from a variable-latency instruction memory over a req/ack handshake.
- Presents each instruction to the ID stage over a valid/ready handshake; branch redirects flush it.

Parameters:
- AddrWidth, 16, width of PC and instruction-memory address.
- InstrWidth, 16, instruction word width.
- InstrBytes, 2, PC increment per sequential instruction.
- ResetVector, 0, PC value driven while in reset.

Ports:
- CLK  in  1  single clock, rising edge.
- RST  in  1  asynchronous, active-low reset.
- PC  in  AddrWidth  current PC from the PC register output.
- PC_Next  out  AddrWidth  value loaded into the PC register on every clock.
- IMem_Req  out  1  fetch request.
- IMem_Addr  out  AddrWidth  fetch address; stable while IMem_Req=1.
- IMem_Ack  in  1  one-cycle response strobe; IMem_Data is valid in that cycle.
- IMem_Data  in  InstrWidth  fetched instruction.
- Branch_Taken  in  1  redirect pulse from EX.
- Branch_Target  in  AddrWidth  redirect address.
- ID_Valid  out  1  ID_Instr/ID_PC valid.
- ID_Ready  in  1  ID accepts when ID_Valid & ID_Ready.
- ID_Instr  out  InstrWidth  held instruction.
- ID_PC  out  AddrWidth  address of ID_Instr.

Behaviour:
- Reset (RST=0, async): state IDLE; IMem_Req=0; IMem_Addr=0; ID_Valid=0; ID_Instr=0; ID_PC=0; PC_Next=ResetVector (combinational while RST=0).
- One outstanding request at most. The output buffer holds one entry.
- States:
  - IDLE: no request outstanding. If Branch_Taken, stay IDLE. Else if buffer free (!ID_Valid, or ID_Valid & ID_Ready this cycle), then at the edge: IMem_Req<=1, IMem_Addr<=PC, go BUSY.
  - BUSY: request outstanding; IMem_Req/IMem_Addr held. On IMem_Ack: IMem_Req<=0, ID_Instr<=IMem_Data, ID_PC<=IMem_Addr, ID_Valid<=1, go IDLE. If Branch_Taken with no Ack, go DROP. If Branch_Taken in the same cycle as Ack, discard the data and go IDLE.
  - DROP: request outstanding, response to be discarded; IMem_Req held. On Ack: IMem_Req<=0, no capture, go IDLE. Branch_Taken in DROP stays DROP; the newest target wins via the PC.
- PC_Next priority:
  - Branch_Target if Branch_Taken.
  - Else PC+InstrBytes (mod 2^AddrWidth) on an Ack captured in BUSY.
  - Else PC (hold).
- Wrap: PC=16'hFFFE with InstrBytes=2 gives PC_Next=16'h0000.
- Branch_Taken clears ID_Valid at the same edge, overriding any capture.
- ID_Valid drops on ID_Valid & ID_Ready unless a new capture occurs at that edge.
- Minimum latency: PC to ID_Valid is 2 cycles with 1-cycle memory (issue edge, ack edge).
- Sequential throughput: one instruction per 2 cycles for 1-cycle memory; no speculative prefetch.
- Reset mid-request: state forced IDLE, any late IMem_Ack is ignored. The memory must tolerate a request withdrawn by reset.
- IMem_Ack in IDLE is ignored.

Optional Feature:
- Macro IF_STALL_COUNT_EN.
- Defined:
  - Adds output port Stall_Count [15:0], reset 0.
  - Increments every cycle with ID_Valid & !ID_Ready; saturates at 16'hFFFF.
  - Cleared on Branch_Taken.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Shared package if_pkg holds:
  - state encoding: IDLE=2'd0, BUSY=2'd1, DROP=2'd2;
  - default InstrBytes and ResetVector constants;
  - the NOP instruction constant for bench use.
- One natural sub-module, if_id_buffer: the valid/ready output register with capture, consume and flush inputs. The FSM and PC_Next mux stay in the top level.

Test Plan:
- Sequential fetch: reset, PC=0, 1-cycle memory returning 16'h1234, ID_Ready=1. Expect IMem_Addr=0, ID_Instr=16'h1234 and ID_PC=0 two cycles after reset release, with PC_Next=2 in the ack cycle.
- Backpressure: ID_Ready=0 for 5 cycles after the first capture. Expect no IMem_Req and ID_Valid held with the instruction stable. Release ID_Ready and expect the next request at IMem_Addr=2 in the same cycle.
- Redirect during BUSY: 3-cycle memory, Branch_Taken with target 16'h0040 at cycle 1 of the wait. Expect state DROP, the data at ack discarded (ID_Valid stays 0), then a request at 16'h0040.
- Redirect coincident with Ack: expect no capture, PC_Next=Branch_Target, and ID_Valid cleared.
- Wrap and reset: PC=16'hFFFE with ack gives PC_Next=0. Assert RST=0 asynchronously mid-BUSY; expect immediate IMem_Req=0, ID_Valid=0 and PC_Next=ResetVector, with a later ack ignored.
- IF_STALL_COUNT_EN: hold ID_Ready=0 for 7 valid cycles and expect Stall_Count=7; then Branch_Taken gives 0.
